// File: rtl/id_hazard_stage_pkg.sv
// Shared decode constants and the ID/EX control word for the MIPS decode stage.
// Control word layout (MSB first): reg_write, mem_read, mem_write, reg_dst, mem_to_reg, alu_src, alu_op.
package id_hazard_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;

  localparam int CTRL_W          = 12;
  localparam int CTRL_REG_WRITE  = 11;
  localparam int CTRL_MEM_READ   = 10;
  localparam int CTRL_MEM_WRITE  = 9;
  localparam int CTRL_REG_DST    = 7;
  localparam int CTRL_MEM_TO_REG = 5;
  localparam int CTRL_ALU_SRC    = 3;
  localparam int CTRL_ALU_OP     = 0;

  localparam logic [1:0] REG_DST_RT      = 2'd0;
  localparam logic [1:0] REG_DST_RD      = 2'd1;
  localparam logic [1:0] REG_DST_RA      = 2'd2;
  localparam logic [1:0] MEM_TO_REG_ALU  = 2'd0;
  localparam logic [1:0] MEM_TO_REG_MEM  = 2'd1;
  localparam logic [1:0] MEM_TO_REG_LINK = 2'd2;
  localparam logic [1:0] ALU_SRC_REG     = 2'd0;
  localparam logic [1:0] ALU_SRC_IMM     = 2'd1;

  localparam logic [2:0] ALU_OP_ADD   = 3'd0;
  localparam logic [2:0] ALU_OP_FUNCT = 3'd1;
  localparam logic [2:0] ALU_OP_AND   = 3'd2;
  localparam logic [2:0] ALU_OP_OR    = 3'd3;
  localparam logic [2:0] ALU_OP_XOR   = 3'd4;
  localparam logic [2:0] ALU_OP_SLT   = 3'd5;
  localparam logic [2:0] ALU_OP_LUI   = 3'd6;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src;
    logic [2:0] alu_op;
  } ctrl_t;

  function automatic logic [4:0] dest_reg(input ctrl_t c, input logic [4:0] rt, input logic [4:0] rd);
    case (c.reg_dst)
      REG_DST_RD: dest_reg = rd;
      REG_DST_RA: dest_reg = 5'd31;
      default:    dest_reg = rt;
    endcase
  endfunction

endpackage

// File: rtl/id_hazard_stage_registers_bank.sv
// GPR bank: edge write (r0 hardwired 0), write-first read bypass, flat debug view.
// Reads are combinational; no backpressure.
module id_hazard_stage_registers_bank #(
  parameter int REGISTERS_BANK_SIZE = 32,
  parameter int BUS_SIZE            = 32
) (
  input  logic                                      i_clk,
  input  logic                                      i_reset,
  input  logic                                      i_we,
  input  logic [$clog2(REGISTERS_BANK_SIZE)-1:0]    i_addr_wr,
  input  logic [BUS_SIZE-1:0]                       i_bus_wr,
  input  logic [$clog2(REGISTERS_BANK_SIZE)-1:0]    i_addr_a,
  input  logic [$clog2(REGISTERS_BANK_SIZE)-1:0]    i_addr_b,
  output logic [BUS_SIZE-1:0]                       o_bus_a,
  output logic [BUS_SIZE-1:0]                       o_bus_b,
  output logic [REGISTERS_BANK_SIZE*BUS_SIZE-1:0]   o_bus_debug
);

  logic [BUS_SIZE-1:0] r_regs [REGISTERS_BANK_SIZE];
  logic                w_wr_ok;

  assign w_wr_ok = i_we && (i_addr_wr != '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < REGISTERS_BANK_SIZE; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[i_addr_wr] <= i_bus_wr;
    end
  end

  assign o_bus_a = (w_wr_ok && (i_addr_wr == i_addr_a)) ? i_bus_wr : r_regs[i_addr_a];
  assign o_bus_b = (w_wr_ok && (i_addr_wr == i_addr_b)) ? i_bus_wr : r_regs[i_addr_b];

  for (genvar g = 0; g < REGISTERS_BANK_SIZE; g++) begin : g_dbg
    assign o_bus_debug[g*BUS_SIZE +: BUS_SIZE] = r_regs[g];
  end

endmodule

// File: rtl/id_hazard_stage.sv
// MIPS ID stage: decode, branch/jump resolution, hazard bubbles, ID/EX register (1-cycle latency).
// Holds everything and stalls fetch while ID/EX is valid and EX is not ready.
module id_hazard_stage
  import id_hazard_stage_pkg::*;
#(
  parameter int REGISTERS_BANK_SIZE = 32,
  parameter int PC_SIZE             = 32,
  parameter int BUS_SIZE            = 32
) (
  input  logic                                     i_clk,
  input  logic                                     i_reset,
  input  logic                                     i_valid,
  input  logic [BUS_SIZE-1:0]                      i_instruction,
  input  logic [PC_SIZE-1:0]                       i_next_seq_pc,
  input  logic                                     i_reg_write_enable,
  input  logic [$clog2(REGISTERS_BANK_SIZE)-1:0]   i_reg_addr_wr,
  input  logic [BUS_SIZE-1:0]                      i_reg_bus_wr,
  input  logic                                     i_mem_reg_write,
  input  logic [$clog2(REGISTERS_BANK_SIZE)-1:0]   i_mem_reg_addr,
  input  logic [BUS_SIZE-1:0]                      i_mem_alu_result,
  input  logic                                     i_mem_is_load,
  input  logic                                     i_ex_ready,
  output logic                                     o_stall,
  output logic                                     o_flush,
  output logic                                     o_next_pc_src,
  output logic [PC_SIZE-1:0]                       o_next_not_seq_pc,
  output logic                                     o_valid,
  output logic [11:0]                              o_ctrl,
  output logic [BUS_SIZE-1:0]                      o_bus_a,
  output logic [BUS_SIZE-1:0]                      o_bus_b,
  output logic [BUS_SIZE-1:0]                      o_imm_ext,
  output logic [PC_SIZE-1:0]                       o_pc_link,
  output logic [20:0]                              o_reg_fields,
  output logic [REGISTERS_BANK_SIZE*BUS_SIZE-1:0]  o_bus_debug
);

  logic [5:0]          w_opcode;
  logic [5:0]          w_funct;
  logic [4:0]          w_rs;
  logic [4:0]          w_rt;
  logic [4:0]          w_rd;
  logic [15:0]         w_imm;
  logic [BUS_SIZE-1:0] w_bank_a;
  logic [BUS_SIZE-1:0] w_bank_b;

  assign w_opcode = i_instruction[31:26];
  assign w_rs     = i_instruction[25:21];
  assign w_rt     = i_instruction[20:16];
  assign w_rd     = i_instruction[15:11];
  assign w_funct  = i_instruction[5:0];
  assign w_imm    = i_instruction[15:0];

  id_hazard_stage_registers_bank #(
    .REGISTERS_BANK_SIZE(REGISTERS_BANK_SIZE),
    .BUS_SIZE           (BUS_SIZE)
  ) u_bank (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_we       (i_reg_write_enable),
    .i_addr_wr  (i_reg_addr_wr),
    .i_bus_wr   (i_reg_bus_wr),
    .i_addr_a   (w_rs),
    .i_addr_b   (w_rt),
    .o_bus_a    (w_bank_a),
    .o_bus_b    (w_bank_b),
    .o_bus_debug(o_bus_debug)
  );

  ctrl_t               w_ctrl;
  logic [BUS_SIZE-1:0] w_imm_ext;
  logic                w_rt_read;
  logic                w_is_beq;
  logic                w_is_bne;
  logic                w_is_j;
  logic                w_is_jr;

  always_comb begin
    w_ctrl    = '0;
    w_imm_ext = {{(BUS_SIZE-16){w_imm[15]}}, w_imm};
    w_rt_read = 1'b0;
    w_is_beq  = 1'b0;
    w_is_bne  = 1'b0;
    w_is_j    = 1'b0;
    w_is_jr   = 1'b0;
    case (w_opcode)
      OP_RTYPE: begin
        if (w_funct == FN_JR) begin
          w_is_jr = 1'b1;
        end else if (w_funct == FN_JALR) begin
          w_is_jr           = 1'b1;
          w_ctrl.reg_write  = 1'b1;
          w_ctrl.reg_dst    = REG_DST_RD;
          w_ctrl.mem_to_reg = MEM_TO_REG_LINK;
        end else begin
          w_rt_read        = 1'b1;
          w_ctrl.reg_write = 1'b1;
          w_ctrl.reg_dst   = REG_DST_RD;
          w_ctrl.alu_src   = ALU_SRC_REG;
          w_ctrl.alu_op    = ALU_OP_FUNCT;
        end
      end
      OP_ADDI, OP_SLTI: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = ALU_SRC_IMM;
        w_ctrl.alu_op    = (w_opcode == OP_ADDI) ? ALU_OP_ADD : ALU_OP_SLT;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        w_imm_ext        = {{(BUS_SIZE-16){1'b0}}, w_imm};
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = ALU_SRC_IMM;
        w_ctrl.alu_op    = (w_opcode == OP_ANDI) ? ALU_OP_AND :
                           (w_opcode == OP_ORI)  ? ALU_OP_OR  : ALU_OP_XOR;
      end
      OP_LUI: begin
        w_imm_ext        = BUS_SIZE'({w_imm, 16'h0000});
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = ALU_SRC_IMM;
        w_ctrl.alu_op    = ALU_OP_LUI;
      end
      OP_LW: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_read   = 1'b1;
        w_ctrl.mem_to_reg = MEM_TO_REG_MEM;
        w_ctrl.alu_src    = ALU_SRC_IMM;
      end
      OP_SW: begin
        w_rt_read        = 1'b1;
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_src   = ALU_SRC_IMM;
      end
      OP_BEQ: begin
        w_rt_read = 1'b1;
        w_is_beq  = 1'b1;
      end
      OP_BNE: begin
        w_rt_read = 1'b1;
        w_is_bne  = 1'b1;
      end
      OP_J: w_is_j = 1'b1;
      OP_JAL: begin
        w_is_j            = 1'b1;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = REG_DST_RA;
        w_ctrl.mem_to_reg = MEM_TO_REG_LINK;
      end
      default: ;
    endcase
  end

  logic                r_valid;
  ctrl_t               r_ctrl;
  logic [BUS_SIZE-1:0] r_bus_a;
  logic [BUS_SIZE-1:0] r_bus_b;
  logic [BUS_SIZE-1:0] r_imm_ext;
  logic [PC_SIZE-1:0]  r_pc_link;
  logic [20:0]         r_reg_fields;

  // Loaded values are still in flight in EX/MEM, so only ALU results may be forwarded.
  logic [BUS_SIZE-1:0] w_fwd_a;
  logic [BUS_SIZE-1:0] w_fwd_b;
  assign w_fwd_a = (i_mem_reg_write && !i_mem_is_load && (i_mem_reg_addr == w_rs) && (w_rs != '0))
                   ? i_mem_alu_result : w_bank_a;
  assign w_fwd_b = (i_mem_reg_write && !i_mem_is_load && (i_mem_reg_addr == w_rt) && (w_rt != '0))
                   ? i_mem_alu_result : w_bank_b;

  logic [4:0] w_idex_rt;
  logic [4:0] w_idex_dest;
  logic       w_br_uses_rt;
  logic       w_load_use;
  logic       w_dep_ex;
  logic       w_dep_mem;
  logic       w_hazard;
  logic       w_hold;
  logic       w_taken;
  logic       w_redirect;

  assign w_idex_rt    = r_reg_fields[15:11];
  assign w_idex_dest  = dest_reg(r_ctrl, r_reg_fields[15:11], r_reg_fields[10:6]);
  assign w_br_uses_rt = w_is_beq || w_is_bne;
  assign w_load_use   = r_valid && r_ctrl.mem_read &&
                        ((w_idex_rt == w_rs) || (w_rt_read && (w_idex_rt == w_rt)));
  assign w_dep_ex     = r_valid && r_ctrl.reg_write &&
                        ((w_idex_dest == w_rs) || (w_br_uses_rt && (w_idex_dest == w_rt)));
  assign w_dep_mem    = i_mem_is_load &&
                        ((i_mem_reg_addr == w_rs) || (w_br_uses_rt && (i_mem_reg_addr == w_rt)));
  assign w_hazard     = i_valid && (w_load_use || ((w_br_uses_rt || w_is_jr) && (w_dep_ex || w_dep_mem)));
  assign w_hold       = r_valid && !i_ex_ready;
  assign w_taken      = (w_is_beq && (w_fwd_a == w_fwd_b)) || (w_is_bne && (w_fwd_a != w_fwd_b)) ||
                        w_is_j || w_is_jr;
  assign w_redirect   = !i_reset && i_valid && !w_hold && !w_hazard && w_taken;

  logic [PC_SIZE-1:0] w_target;
  always_comb begin
    w_target = i_next_seq_pc + PC_SIZE'(w_imm_ext << 2);
    if (w_is_jr) begin
      w_target = PC_SIZE'(w_fwd_a);
    end else if (w_is_j) begin
      w_target = {i_next_seq_pc[PC_SIZE-1:28], i_instruction[25:0], 2'b00};
    end
  end

  assign o_stall           = !i_reset && (w_hold || w_hazard);
  assign o_flush           = w_redirect;
  assign o_next_pc_src     = w_redirect;
  assign o_next_not_seq_pc = i_reset ? '0 : w_target;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid      <= 1'b0;
      r_ctrl       <= '0;
      r_bus_a      <= '0;
      r_bus_b      <= '0;
      r_imm_ext    <= '0;
      r_pc_link    <= '0;
      r_reg_fields <= '0;
    end else if (!w_hold) begin
      if (w_hazard) begin
        r_valid <= 1'b0;
        r_ctrl  <= '0;
      end else begin
        r_valid      <= i_valid;
        r_ctrl       <= i_valid ? w_ctrl : '0;
        r_bus_a      <= w_bank_a;
        r_bus_b      <= w_bank_b;
        r_imm_ext    <= w_imm_ext;
        r_pc_link    <= i_next_seq_pc + PC_SIZE'(4);
        r_reg_fields <= {w_rs, w_rt, w_rd, w_funct};
      end
    end
  end

  assign o_valid      = r_valid;
  assign o_ctrl       = r_ctrl;
  assign o_bus_a      = r_bus_a;
  assign o_bus_b      = r_bus_b;
  assign o_imm_ext    = r_imm_ext;
  assign o_pc_link    = r_pc_link;
  assign o_reg_fields = r_reg_fields;

endmodule

// File: tb/tb_id_hazard_stage.sv
// Directed bench for id_hazard_stage: hand-computed vectors, immediate-assertion checks.
module tb_id_hazard_stage;

  logic          i_clk;
  logic          i_reset;
  logic          i_valid;
  logic [31:0]   i_instruction;
  logic [31:0]   i_next_seq_pc;
  logic          i_reg_write_enable;
  logic [4:0]    i_reg_addr_wr;
  logic [31:0]   i_reg_bus_wr;
  logic          i_mem_reg_write;
  logic [4:0]    i_mem_reg_addr;
  logic [31:0]   i_mem_alu_result;
  logic          i_mem_is_load;
  logic          i_ex_ready;
  logic          o_stall;
  logic          o_flush;
  logic          o_next_pc_src;
  logic [31:0]   o_next_not_seq_pc;
  logic          o_valid;
  logic [11:0]   o_ctrl;
  logic [31:0]   o_bus_a;
  logic [31:0]   o_bus_b;
  logic [31:0]   o_imm_ext;
  logic [31:0]   o_pc_link;
  logic [20:0]   o_reg_fields;
  logic [1023:0] o_bus_debug;

  int checks   = 0;
  int failures = 0;

  id_hazard_stage dut (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_valid           (i_valid),
    .i_instruction     (i_instruction),
    .i_next_seq_pc     (i_next_seq_pc),
    .i_reg_write_enable(i_reg_write_enable),
    .i_reg_addr_wr     (i_reg_addr_wr),
    .i_reg_bus_wr      (i_reg_bus_wr),
    .i_mem_reg_write   (i_mem_reg_write),
    .i_mem_reg_addr    (i_mem_reg_addr),
    .i_mem_alu_result  (i_mem_alu_result),
    .i_mem_is_load     (i_mem_is_load),
    .i_ex_ready        (i_ex_ready),
    .o_stall           (o_stall),
    .o_flush           (o_flush),
    .o_next_pc_src     (o_next_pc_src),
    .o_next_not_seq_pc (o_next_not_seq_pc),
    .o_valid           (o_valid),
    .o_ctrl            (o_ctrl),
    .o_bus_a           (o_bus_a),
    .o_bus_b           (o_bus_b),
    .o_imm_ext         (o_imm_ext),
    .o_pc_link         (o_pc_link),
    .o_reg_fields      (o_reg_fields),
    .o_bus_debug       (o_bus_debug)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  task automatic wb(input logic we, input logic [4:0] addr, input logic [31:0] dat);
    i_reg_write_enable = we;
    i_reg_addr_wr      = addr;
    i_reg_bus_wr       = dat;
  endtask

  task automatic mem(input logic wr, input logic [4:0] addr, input logic [31:0] res, input logic ld);
    i_mem_reg_write  = wr;
    i_mem_reg_addr   = addr;
    i_mem_alu_result = res;
    i_mem_is_load    = ld;
  endtask

  initial begin
    i_reset = 1'b1;
    i_valid = 1'b1;
    i_instruction = enc_j(6'h02, 26'h40);
    i_next_seq_pc = 32'h0;
    i_ex_ready = 1'b1;
    wb(1'b0, 5'd0, 32'h0);
    mem(1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    chk("rst_pc_src", 64'(o_next_pc_src), 64'd0);
    chk("rst_flush", 64'(o_flush), 64'd0);
    chk("rst_stall", 64'(o_stall), 64'd0);
    chk("rst_target", 64'(o_next_not_seq_pc), 64'd0);
    tick();
    tick();
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_ctrl", 64'(o_ctrl), 64'd0);
    chk("rst_debug", 64'(|o_bus_debug), 64'd0);

    // WB writes r5, then ADD r6,r5,r0 while r1=7 is written through the bypass
    i_reset = 1'b0;
    i_valid = 1'b0;
    wb(1'b1, 5'd5, 32'h1234);
    tick();
    i_valid = 1'b1;
    i_instruction = enc_r(5'd5, 5'd0, 5'd6, 6'h20);
    i_next_seq_pc = 32'h10;
    wb(1'b1, 5'd1, 32'd7);
    #1;
    chk("add_stall", 64'(o_stall), 64'd0);
    tick();
    chk("add_valid", 64'(o_valid), 64'd1);
    chk("add_bus_a", 64'(o_bus_a), 64'h1234);
    chk("add_ctrl", 64'(o_ctrl), 64'h881);
    chk("add_fields", 64'(o_reg_fields), 64'({5'd5, 5'd0, 5'd6, 6'h20}));
    chk("dbg_r1", 64'(o_bus_debug[1*32 +: 32]), 64'd7);

    // LW r2,0(r1) then ADD r3,r2,r4 -> one bubble
    i_instruction = enc_i(6'h23, 5'd1, 5'd2, 16'h0);
    wb(1'b1, 5'd4, 32'd3);
    tick();
    chk("lw_valid", 64'(o_valid), 64'd1);
    chk("lw_ctrl", 64'(o_ctrl), 64'hC28);
    chk("lw_imm", 64'(o_imm_ext), 64'd0);
    wb(1'b0, 5'd0, 32'h0);
    i_instruction = enc_r(5'd2, 5'd4, 5'd3, 6'h20);
    #1;
    chk("lu_stall", 64'(o_stall), 64'd1);
    chk("lu_pc_src", 64'(o_next_pc_src), 64'd0);
    tick();
    chk("lu_bubble_valid", 64'(o_valid), 64'd0);
    chk("lu_bubble_ctrl", 64'(o_ctrl), 64'd0);
    mem(1'b1, 5'd2, 32'h0, 1'b1);
    #1;
    chk("lu_release", 64'(o_stall), 64'd0);
    tick();
    chk("lu_add_valid", 64'(o_valid), 64'd1);
    chk("lu_add_ctrl", 64'(o_ctrl), 64'h881);
    chk("lu_add_fields", 64'(o_reg_fields), 64'({5'd2, 5'd4, 5'd3, 6'h20}));
    chk("lu_add_bus_b", 64'(o_bus_b), 64'd3);
    mem(1'b0, 5'd0, 32'h0, 1'b0);

    // BEQ r1,r2,+4 with both = 7 at next_seq_pc 0x100
    i_valid = 1'b0;
    wb(1'b1, 5'd2, 32'd7);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    i_valid = 1'b1;
    i_instruction = enc_i(6'h04, 5'd1, 5'd2, 16'd4);
    i_next_seq_pc = 32'h100;
    #1;
    chk("beq_pc_src", 64'(o_next_pc_src), 64'd1);
    chk("beq_target", 64'(o_next_not_seq_pc), 64'h110);
    chk("beq_flush", 64'(o_flush), 64'd1);
    chk("beq_stall", 64'(o_stall), 64'd0);
    tick();
    chk("beq_imm", 64'(o_imm_ext), 64'd4);
    i_valid = 1'b0;
    wb(1'b1, 5'd1, 32'd9);
    #1;
    chk("beq_flush_once", 64'(o_flush), 64'd0);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    chk("dbg_r1_9", 64'(o_bus_debug[1*32 +: 32]), 64'd9);

    // BNE r1,r0 with EX/MEM forwarding r1=0 -> not taken
    i_valid = 1'b1;
    i_instruction = enc_i(6'h05, 5'd1, 5'd0, 16'd8);
    i_next_seq_pc = 32'h300;
    mem(1'b1, 5'd1, 32'h0, 1'b0);
    #1;
    chk("bne_pc_src", 64'(o_next_pc_src), 64'd0);
    chk("bne_flush", 64'(o_flush), 64'd0);
    chk("bne_stall", 64'(o_stall), 64'd0);
    tick();
    mem(1'b0, 5'd0, 32'h0, 1'b0);

    // JAL 0x40 at next_seq_pc 0x204
    i_instruction = enc_j(6'h03, 26'h40);
    i_next_seq_pc = 32'h204;
    #1;
    chk("jal_pc_src", 64'(o_next_pc_src), 64'd1);
    chk("jal_target", 64'(o_next_not_seq_pc), 64'h100);
    tick();
    chk("jal_link", 64'(o_pc_link), 64'h208);
    chk("jal_ctrl", 64'(o_ctrl), 64'h940);

    // EX not ready for 3 cycles with a J waiting in ID
    i_instruction = enc_j(6'h02, 26'h80);
    i_next_seq_pc = 32'h400;
    i_ex_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_stall", 64'(o_stall), 64'd1);
      chk("hold_pc_src", 64'(o_next_pc_src), 64'd0);
      chk("hold_flush", 64'(o_flush), 64'd0);
      tick();
      chk("hold_link", 64'(o_pc_link), 64'h208);
      chk("hold_ctrl", 64'(o_ctrl), 64'h940);
      chk("hold_valid", 64'(o_valid), 64'd1);
    end
    i_ex_ready = 1'b1;
    #1;
    chk("rel_pc_src", 64'(o_next_pc_src), 64'd1);
    chk("rel_target", 64'(o_next_not_seq_pc), 64'h200);
    chk("rel_stall", 64'(o_stall), 64'd0);
    tick();
    chk("rel_link", 64'(o_pc_link), 64'h404);
    chk("rel_ctrl", 64'(o_ctrl), 64'd0);

    // write to r0 is dropped, bypass included
    wb(1'b1, 5'd0, 32'hFFFF);
    i_instruction = enc_r(5'd0, 5'd0, 5'd7, 6'h20);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    chk("r0_bus_a", 64'(o_bus_a), 64'd0);
    chk("r0_debug", 64'(o_bus_debug[0 +: 32]), 64'd0);

    // branch on ALU result: one bubble, then EX/MEM forward
    i_instruction = enc_r(5'd0, 5'd0, 5'd10, 6'h20);
    tick();
    i_instruction = enc_i(6'h04, 5'd10, 5'd0, 16'd1);
    i_next_seq_pc = 32'h500;
    #1;
    chk("bdep_stall", 64'(o_stall), 64'd1);
    chk("bdep_pc_src", 64'(o_next_pc_src), 64'd0);
    tick();
    chk("bdep_bubble", 64'(o_valid), 64'd0);
    mem(1'b1, 5'd10, 32'h0, 1'b0);
    #1;
    chk("bdep_fwd_stall", 64'(o_stall), 64'd0);
    chk("bdep_fwd_pc_src", 64'(o_next_pc_src), 64'd1);
    chk("bdep_fwd_target", 64'(o_next_not_seq_pc), 64'h504);
    tick();
    mem(1'b0, 5'd0, 32'h0, 1'b0);

    // reset asserted during a load-use stall
    i_instruction = enc_i(6'h23, 5'd0, 5'd8, 16'h0);
    tick();
    i_instruction = enc_r(5'd8, 5'd0, 5'd9, 6'h20);
    #1;
    chk("rlu_stall", 64'(o_stall), 64'd1);
    i_reset = 1'b1;
    #1;
    chk("rlu_stall_rst", 64'(o_stall), 64'd0);
    tick();
    chk("rlu_valid", 64'(o_valid), 64'd0);
    chk("rlu_ctrl", 64'(o_ctrl), 64'd0);
    chk("rlu_dbg_r5", 64'(o_bus_debug[5*32 +: 32]), 64'd0);
    i_reset = 1'b0;
    #1;
    chk("rlu_after_stall", 64'(o_stall), 64'd0);
    tick();
    chk("rlu_add_valid", 64'(o_valid), 64'd1);
    chk("rlu_add_fields", 64'(o_reg_fields), 64'({5'd8, 5'd0, 5'd9, 6'h20}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
